// File: rtl/jkff_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK flip-flops among NREQ requesters.
// Optional op-check logic enabled by defining JKFF_ARB_CHECK_EN.
module jkff_bank_arbiter #(
   parameter int NREQ = 4,
   parameter int NFF  = 8,
   parameter int IDXW = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [2*NREQ-1:0]      req_op,
   input  logic [IDXW*NREQ-1:0]   req_idx,
   output logic [NREQ-1:0]        gnt,
   output logic                   busy,
   output logic                   done,
   output logic                   done_q,
   output logic                   done_err,
   output logic [NFF-1:0]         ff_j,
   output logic [NFF-1:0]         ff_k,
   input  logic [NFF-1:0]         ff_q,
   output logic                   mismatch
);

   localparam int PTRW = $clog2(NREQ);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] GRANT  = 2'd1;
   localparam logic [1:0] DRIVE  = 2'd2;
   localparam logic [1:0] SETTLE = 2'd3;

   logic [1:0]      state;
   logic [PTRW-1:0] ptr;
   logic [1:0]      op_r;
   logic [IDXW-1:0] idx_r;
   logic [NFF-1:0]  j_r;
   logic [NFF-1:0]  k_r;

   logic            arb_found;
   logic [PTRW-1:0] arb_win;
   logic [PTRW-1:0] cand;
   logic [1:0]      arb_op;
   logic [IDXW-1:0] arb_idx;
   logic [NREQ-1:0] arb_onehot;

   logic [NFF-1:0]  ff_sel;
   logic            idx_valid;
   logic            q_sel;

   // Search starts one past the last winner and wraps, giving round-robin fairness.
   always_comb begin
      arb_found = 1'b0;
      arb_win   = '0;
      cand      = ptr;
      for (int i = 0; i < NREQ; i++) begin
         cand = (cand == PTRW'(NREQ - 1)) ? '0 : cand + PTRW'(1);
         if (!arb_found && req[cand]) begin
            arb_found = 1'b1;
            arb_win   = cand;
         end
      end
   end

   always_comb begin
      arb_op     = '0;
      arb_idx    = '0;
      arb_onehot = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (arb_win == PTRW'(r)) begin
            arb_op  = req_op[2*r +: 2];
            arb_idx = req_idx[IDXW*r +: IDXW];
         end
         arb_onehot[r] = arb_found && (arb_win == PTRW'(r));
      end
   end

   // An out-of-range index matches no bit, so nothing is driven and idx_valid drops.
   always_comb begin
      ff_sel = '0;
      for (int i = 0; i < NFF; i++) begin
         ff_sel[i] = (idx_r == IDXW'(i));
      end
   end

   assign idx_valid = |ff_sel;
   assign q_sel     = |(ff_q & ff_sel);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= PTRW'(NREQ - 1);
         op_r     <= '0;
         idx_r    <= '0;
         j_r      <= '0;
         k_r      <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         done_q   <= 1'b0;
         done_err <= 1'b0;
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_found) begin
                  state <= GRANT;
                  ptr   <= arb_win;
                  op_r  <= arb_op;
                  idx_r <= arb_idx;
                  gnt   <= arb_onehot;
                  busy  <= 1'b1;
               end
            end
            GRANT: begin
               state <= DRIVE;
               j_r   <= ff_sel & {NFF{op_r[1]}};
               k_r   <= ff_sel & {NFF{op_r[0]}};
            end
            DRIVE: begin
               state <= SETTLE;
               j_r   <= '0;
               k_r   <= '0;
            end
            SETTLE: begin
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b1;
               done_q   <= idx_valid & q_sel;
               done_err <= ~idx_valid;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset asserted during DRIVE must keep the bank from updating on that same edge.
   assign ff_j = j_r & {NFF{~rst}};
   assign ff_k = k_r & {NFF{~rst}};

`ifdef JKFF_ARB_CHECK_EN
   logic prev_q;
   logic exp_q;
   logic mm_r;

   always_comb begin
      exp_q = prev_q;
      case (op_r)
         2'b00:   exp_q = prev_q;
         2'b01:   exp_q = 1'b0;
         2'b10:   exp_q = 1'b1;
         default: exp_q = ~prev_q;
      endcase
   end

   // prev_q holds the pre-edge value of the target, captured on the edge the bank updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
         mm_r   <= 1'b0;
      end else begin
         if (state == DRIVE) begin
            prev_q <= q_sel;
         end
         if (state == SETTLE && idx_valid && (q_sel != exp_q)) begin
            mm_r <= 1'b1;
         end
      end
   end

   assign mismatch = mm_r;
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_jkff_bank_arbiter.sv
// Self-checking bench for jkff_bank_arbiter: vector table plus a done-side scoreboard.
module tb_jkff_bank_arbiter;

   localparam int NREQ = 4;
   localparam int NFF  = 6;
   localparam int IDXW = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [2*NREQ-1:0]    req_op;
   logic [IDXW*NREQ-1:0] req_idx;
   logic [NREQ-1:0]      gnt;
   logic                 busy;
   logic                 done;
   logic                 done_q;
   logic                 done_err;
   logic [NFF-1:0]       ff_j;
   logic [NFF-1:0]       ff_k;
   logic [NFF-1:0]       bank_q;
   logic                 mismatch;

   logic                 bank_clr;
   logic                 bad_bank;
   logic [NFF-1:0]       model_q;
   logic                 exp_mm;

   typedef struct {
      int              r;
      logic [1:0]      op;
      logic [IDXW-1:0] idx;
      logic [NFF-1:0]  exp_j;
      logic [NFF-1:0]  exp_k;
      logic            exp_q;
      logic            exp_err;
   } vec_t;

   typedef struct {
      logic q;
      logic err;
   } sb_t;

   vec_t vecs[10];
   vec_t mv;
   sb_t  sbq[$];
   int   checks = 0;
   int   errors = 0;

   jkff_bank_arbiter #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_op   (req_op),
      .req_idx  (req_idx),
      .gnt      (gnt),
      .busy     (busy),
      .done     (done),
      .done_q   (done_q),
      .done_err (done_err),
      .ff_j     (ff_j),
      .ff_k     (ff_k),
      .ff_q     (bank_q),
      .mismatch (mismatch)
   );

   always #5 clk = ~clk;

   // JK bank model; bad_bank makes flip-flop 2 ignore its k pin.
   always @(posedge clk) begin
      if (bank_clr) begin
         bank_q <= '0;
      end else begin
         for (int i = 0; i < NFF; i++) begin
            case ({ff_j[i], ff_k[i] & ~(bad_bank && i == 2)})
               2'b01:   bank_q[i] <= 1'b0;
               2'b10:   bank_q[i] <= 1'b1;
               2'b11:   bank_q[i] <= ~bank_q[i];
               default: bank_q[i] <= bank_q[i];
            endcase
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic logic jk(input logic q, input logic [1:0] op, input logic fault);
      logic kk;
      kk = op[0] & ~fault;
      case ({op[1], kk})
         2'b00:   return q;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~q;
      endcase
   endfunction

   task automatic modelOp(input int idx, input logic [1:0] op);
      if (idx < NFF) model_q[idx] = jk(model_q[idx], op, bad_bank && idx == 2);
   endtask

   task automatic pushExp(input logic q, input logic err);
      sb_t e;
      e.q   = q;
      e.err = err;
      sbq.push_back(e);
   endtask

   task automatic setReq(input int r, input logic on, input logic [1:0] op, input logic [IDXW-1:0] idx);
      req[r]                  = on;
      req_op[2*r +: 2]        = op;
      req_idx[IDXW*r +: IDXW] = idx;
   endtask

   task automatic waitGnt(output int n);
      n = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (gnt !== '0) begin
            n = c;
            break;
         end
      end
      if (n == 0) checkOutput("gnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitDrain();
      for (int c = 0; c < 20; c++) begin
         if (sbq.size() == 0) break;
         @(posedge clk);
      end
      checkOutput("drain", 32'(sbq.size()), 32'd0);
   endtask

   // One complete single-requester op with per-phase timing checks.
   task automatic applyStimulus(input vec_t v);
      int n;
      pushExp(v.exp_q, v.exp_err);
      @(posedge clk); #1;
      setReq(v.r, 1'b1, v.op, v.idx);
      waitGnt(n);
      checkOutput("gnt_latency", 32'(n), 32'd2);
      checkOutput("gnt", 32'(gnt), 32'(1) << v.r);
      @(posedge clk); #1;
      req[v.r] = 1'b0;
      @(negedge clk);
      checkOutput("ff_j", 32'(ff_j), 32'(v.exp_j));
      checkOutput("ff_k", 32'(ff_k), 32'(v.exp_k));
      checkOutput("busy_drive", 32'(busy), 32'd1);
      modelOp(int'(v.idx), v.op);
      @(negedge clk);
      checkOutput("done_early", 32'(done), 32'd0);
      @(negedge clk);
      checkOutput("done_latency", 32'(done), 32'd1);
      checkOutput("busy_done", 32'(busy), 32'd0);
   endtask

   // Scoreboard: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin : monitor
      sb_t e;
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            checkOutput("done_q", 32'(done_q), 32'(e.q));
            checkOutput("done_err", 32'(done_err), 32'(e.err));
         end
      end
   end

   initial begin
      int n;
      rst      = 1'b1;
      bank_clr = 1'b1;
      bad_bank = 1'b0;
      req      = '0;
      req_op   = '0;
      req_idx  = '0;
      model_q  = '0;
`ifdef JKFF_ARB_CHECK_EN
      exp_mm   = 1'b1;
`else
      exp_mm   = 1'b0;
`endif

      //          r  op     idx   exp_j  exp_k  q     err
      vecs[0] = '{0, 2'b10, 3'd5, 6'h20, 6'h00, 1'b1, 1'b0};
      vecs[1] = '{2, 2'b10, 3'd3, 6'h08, 6'h00, 1'b1, 1'b0};
      vecs[2] = '{2, 2'b01, 3'd3, 6'h00, 6'h08, 1'b0, 1'b0};
      vecs[3] = '{2, 2'b00, 3'd3, 6'h00, 6'h00, 1'b0, 1'b0};
      vecs[4] = '{1, 2'b11, 3'd0, 6'h01, 6'h01, 1'b1, 1'b0};
      vecs[5] = '{1, 2'b11, 3'd0, 6'h01, 6'h01, 1'b0, 1'b0};
      vecs[6] = '{3, 2'b10, 3'd7, 6'h00, 6'h00, 1'b0, 1'b1};
      vecs[7] = '{0, 2'b10, 3'd6, 6'h00, 6'h00, 1'b0, 1'b1};
      vecs[8] = '{3, 2'b00, 3'd5, 6'h00, 6'h00, 1'b1, 1'b0};
      vecs[9] = '{1, 2'b01, 3'd5, 6'h00, 6'h20, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      bank_clr = 1'b0;
      @(negedge clk);
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_ff_j", 32'(ff_j), 32'd0);
      checkOutput("rst_ff_k", 32'(ff_k), 32'd0);
      checkOutput("rst_mismatch", 32'(mismatch), 32'd0);

      for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
      waitDrain();

      // Pointer back to NREQ-1, then all four requesters toggle their own index for two laps.
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++) setReq(r, 1'b1, 2'b11, IDXW'(r));
      for (int g = 0; g < 2*NREQ; g++) begin
         waitGnt(n);
         checkOutput("rr_gnt", 32'(gnt), 32'(1) << (g % NREQ));
         modelOp(g % NREQ, 2'b11);
         pushExp(model_q[g % NREQ], 1'b0);
      end
      @(posedge clk); #1;
      req = '0;
      waitDrain();

      // Reset landing in DRIVE: the bank must not see the set.
      @(posedge clk); #1;
      setReq(1, 1'b1, 2'b10, 3'd4);
      waitGnt(n);
      checkOutput("abort_gnt", 32'(gnt), 32'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      checkOutput("abort_drive_j", 32'(ff_j), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_gnt_clr", 32'(gnt), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_done_q", 32'(done_q), 32'd0);
      checkOutput("abort_done_err", 32'(done_err), 32'd0);
      checkOutput("abort_ff_j", 32'(ff_j), 32'd0);
      checkOutput("abort_ff_k", 32'(ff_k), 32'd0);
      checkOutput("abort_bank", 32'(bank_q), 32'(model_q));

      // Requesters 3 and 0 together after reset: 0 wins first.
      modelOp(1, 2'b10);
      pushExp(model_q[1], 1'b0);
      modelOp(1, 2'b01);
      pushExp(model_q[1], 1'b0);
      @(posedge clk); #1;
      setReq(0, 1'b1, 2'b10, 3'd1);
      setReq(3, 1'b1, 2'b01, 3'd1);
      waitGnt(n);
      checkOutput("pri_first", 32'(gnt), 32'd1);
      @(posedge clk); #1;
      req[0] = 1'b0;
      waitGnt(n);
      checkOutput("pri_second", 32'(gnt), 32'd8);
      @(posedge clk); #1;
      req[3] = 1'b0;
      waitDrain();

      // Faulty ff2 ignores k: a reset op on a set flip-flop leaves it at 1.
      bad_bank = 1'b1;
      mv = '{2, 2'b10, 3'd2, 6'h04, 6'h00, 1'b1, 1'b0};
      applyStimulus(mv);
      checkOutput("mm_before", 32'(mismatch), 32'd0);
      mv = '{2, 2'b01, 3'd2, 6'h00, 6'h04, 1'b1, 1'b0};
      applyStimulus(mv);
      @(negedge clk);
      checkOutput("mm_set", 32'(mismatch), 32'(exp_mm));
      mv = '{0, 2'b10, 3'd0, 6'h01, 6'h00, 1'b1, 1'b0};
      applyStimulus(mv);
      @(negedge clk);
      checkOutput("mm_hold", 32'(mismatch), 32'(exp_mm));
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      checkOutput("mm_cleared", 32'(mismatch), 32'd0);
      waitDrain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
